// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline plus the MULT/DIV busy sequencer.
// Latency: enables and flushes are combinational (same cycle); only the MULT/DIV FSM is registered.
// Backpressure: dmem wait freezes every stage, branch flushes, HI/LO or load-use holds ID, imem wait bubbles ID.
module pipeline_stall_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MUL_CYCLES     = 4,
    parameter int DIV_CYCLES     = 32,
    parameter int CNT_WIDTH      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_hilo,
    input  logic                      ex_memRead,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      ex_md_start,
    input  logic                      ex_md_is_div,
    input  logic                      ex_branch_taken,
    input  logic                      imem_ready,
    input  logic                      mem_access,
    input  logic                      dmem_ready,
    output logic                      PC_write,
    output logic                      IFID_write,
    output logic                      IDEX_write,
    output logic                      EXMEM_write,
    output logic                      IFID_flush,
    output logic                      IDEX_flush,
    output logic                      MEMWB_bubble,
    output logic                      md_busy,
    output logic                      md_done,
    output logic [1:0]                md_state
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [CNT_WIDTH-1:0] MUL_LOAD = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DIV_LOAD = CNT_WIDTH'(DIV_CYCLES - 1);

    md_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic dmem_stall;
    logic imem_stall;
    logic load_use;
    logic hilo_stall;
    logic md_accept;

    // EXMEM_write is low only in reset or on a dmem freeze, so acceptance is
    // expressed from those terms directly to keep the logic loop-free.
    always_comb begin
        dmem_stall = mem_access & ~dmem_ready;
        imem_stall = ~imem_ready;
        load_use   = ex_memRead && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        md_accept  = ex_md_start & ~dmem_stall & ~rst;
        hilo_stall = id_uses_hilo & ((state_q == MD_RUN) | md_accept);
    end

    always_comb begin
        PC_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        EXMEM_write  = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        MEMWB_bubble = 1'b0;
        if (rst) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            IFID_flush   = 1'b1;
            IDEX_flush   = 1'b1;
            MEMWB_bubble = 1'b1;
        end else if (dmem_stall) begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_write  = 1'b0;
            MEMWB_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // Anything stalled behind the branch is wrong-path, so flush wins.
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (hilo_stall || load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
        end else if (imem_stall) begin
            PC_write   = 1'b0;
            IFID_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A start arriving in RUN is a protocol violation; it restarts the unit.
        if (md_accept) begin
            state_d = MD_RUN;
            cnt_d   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
        end else begin
            case (state_q)
                MD_RUN: begin
                    if (cnt_q == '0) begin
                        state_d = MD_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy  = (state_q == MD_RUN) & ~rst;
    assign md_done  = (state_q == MD_DONE) & ~rst;
    assign md_state = state_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. Each cycle it takes the load-use, branch, instruction/data memory wait and multi-cycle MULT/DIV conditions, resolves them by fixed priority, and drives every pipeline-register write enable and flush. It also owns the MULT/DIV busy sequencer that interlocks HI/LO readers.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- MUL_CYCLES, 4, MULT execution cycles (≥1)
- DIV_CYCLES, 32, DIV execution cycles (≥1)
- CNT_WIDTH, 6, MULT/DIV countdown width; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_rs, id_rt  input  REG_ADDR_WIDTH  source registers of ID instruction
- id_uses_hilo  input  1  ID instruction is MFHI/MFLO/MTHI/MTLO/MULT/DIV
- ex_memRead  input  1  EX instruction is a load
- ex_rt  input  REG_ADDR_WIDTH  load destination in EX
- ex_md_start  input  1  EX instruction is MULT/DIV
- ex_md_is_div  input  1  qualifies ex_md_start: 1=DIV, 0=MULT
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- imem_ready  input  1  instruction fetch completes this cycle
- mem_access  input  1  MEM stage holds load/store
- dmem_ready  input  1  data access completes this cycle
- PC_write, IFID_write, IDEX_write, EXMEM_write  output  1 each  register enables
- IFID_flush, IDEX_flush  output  1 each  load bubble (overrides write)
- MEMWB_bubble  output  1  WB receives a no-op
- md_busy  output  1  MULT/DIV in progress
- md_done  output  1  HI/LO written by datapath at end of this cycle
- md_state  output  2  IDLE=0, RUN=1, DONE=2

## Operation
- Control outputs are combinational from inputs and registered state (same-cycle response); only the MULT/DIV FSM and counter are registered.
- Conditions:
  - dmem_stall = mem_access & ~dmem_ready
  - hilo_stall = id_uses_hilo & (md_state==RUN | md_accept)
  - load_use = ex_memRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt)
  - imem_stall = ~imem_ready
  - md_accept = ex_md_start & EXMEM_write
- Priority, first match wins:
  1. dmem_stall: all four write enables 0, both flushes 0, MEMWB_bubble=1.
  2. ex_branch_taken: all writes 1, IFID_flush=1, IDEX_flush=1. Branch beats stalls; stalled instructions are wrong-path.
  3. hilo_stall or load_use: PC_write=0, IFID_write=0, IDEX_write=1, IDEX_flush=1, EXMEM_write=1. imem_stall ignored; ID instruction held.
  4. imem_stall: PC_write=0, IFID_write=1, IFID_flush=1, rest 1.
  5. Default: all writes 1, flushes 0, MEMWB_bubble=0.
- MULT/DIV FSM:
  - IDLE→RUN on md_accept; load count with (ex_md_is_div ? DIV_CYCLES : MUL_CYCLES)-1.
  - RUN: count decrements every cycle, including dmem_stall cycles (unit runs independently). At count==0, go to DONE.
  - DONE: lasts one cycle, then IDLE. md_accept in DONE goes directly to RUN with a fresh count.
  - md_accept in RUN is a protocol violation; required behaviour is a restart with a fresh count.
- md_busy = (state==RUN); md_done = (state==DONE). No HI/LO stall in DONE.

## Timing
- Reset (async assert, any cycle, mid-op included):
  - state=IDLE, count=0.
  - While rst=1: all write enables 0, IFID_flush=IDEX_flush=MEMWB_bubble=1, md_busy=md_done=0.
  - First cycle after release follows normal priority.
- MULT accepted in cycle T: RUN in T+1..T+MUL_CYCLES; DONE in T+MUL_CYCLES+1; IDLE in T+MUL_CYCLES+2. DIV is the same with DIV_CYCLES.
- MFHI in ID behind a MULT in EX at T is stalled from T through T+MUL_CYCLES and advances to EX in T+MUL_CYCLES+1.
- Load-use: exactly one bubble per hazard; the stall drops the next cycle because the load has left EX.
- ex_md_start held during dmem_stall is not accepted until the first non-frozen cycle.

## Test plan
- Load-use: ex_memRead=1, ex_rt=5, id_rs=5 → PC_write=0, IFID_write=0, IDEX_flush=1 for one cycle. Same with ex_rt=0 → no stall.
- MULT then MFHI, MUL_CYCLES=4: md_accept at T, id_uses_hilo=1 → stall T..T+4, md_busy T+1..T+4, md_done at T+5, MFHI issues at T+5.
- DIV with mem_access=1, dmem_ready=0 during T+3..T+6 → counter still reaches DONE at T+33; all writes 0 and MEMWB_bubble=1 during the freeze.
- Branch taken with simultaneous load_use and imem_ready=0 → PC_write=1, IFID_flush=1, IDEX_flush=1.
- imem_ready=0 for 3 cycles → PC_write=0 and IFID_flush=1 for 3 cycles, then default.
- Assert rst while md_state=RUN with count=10 → state=IDLE immediately (async), reset output values; after release, md_busy=0.
